mul_ctrl: RTL and testbench
===========================

# mul_ctrl

Sequencing and sign-handling stage directly upstream of the iterative unsigned `multiplier`. Accepts RV32M multiply requests (MUL, MULH, MULHSU, MULHU) from the execute stage and converts signed operands to magnitudes. Issues the magnitudes to the multiplier, waits for its result, restores the sign and selects the low or high word. Returns a 32-bit result to writeback over a valid/ack handshake, and supports flushing in-flight work.

## Interface
Parameters:
- `SWAP_EN`, default 1: when 1, the operand with the smaller popcount is routed to `mul_op2_o` to cut multiplier latency.

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `vld_i`  in  1  request valid
- `rdy_o`  out  1  stage can accept; a request is taken when `vld_i & rdy_o`
- `funct3_i`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx is treated as MULHU
- `rs1_i`  in  32  operand A
- `rs2_i`  in  32  operand B
- `rd_idx_i`  in  5  destination register tag
- `flush_i`  in  1  discard any accepted or in-flight request
- `res_vld_o`  out  1  result valid
- `res_o`  out  32  result word
- `rd_idx_o`  out  5  tag of `res_o`
- `res_ack_i`  in  1  downstream consumed the result
- `mul_op1_o`  out  32  multiplicand magnitude to multiplier
- `mul_op2_o`  out  32  multiplier magnitude to multiplier
- `mul_vld_o`  out  1  multiplier start strobe
- `mul_res_i`  in  64  unsigned product from multiplier
- `mul_rdy_i`  in  1  one-cycle product-valid pulse from multiplier

## Operation
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- **IDLE:** `rdy_o=1`. On accept, capture the following:
  - `a_neg = rs1[31] & (MULH|MULHSU)`.
  - `b_neg = rs2[31] & MULH`.
  - `neg = a_neg ^ b_neg`.
  - `|A|`, `|B|` as 32-bit two's-complement magnitudes (0x80000000 stays 0x80000000).
  - `hi = (funct3 != MUL)`.
  - `rd_idx`.
- **Zero fast path:** if `rs1_i==0` or `rs2_i==0`, go directly to DONE with result 0; `mul_vld_o` is not asserted.
- **Otherwise:** go to ISSUE.
- **Operand routing:** when `SWAP_EN=1` and popcount(|A|) < popcount(|B|), |A| goes to `mul_op2_o` and |B| to `mul_op1_o`. Otherwise |A| goes to op1 and |B| to op2; ties keep this order. `SWAP_EN=0` always uses the unswapped order.
- **ISSUE:** `mul_vld_o=1` for exactly one cycle, then WAIT.
- **WAIT:** hold `mul_op1_o`/`mul_op2_o` stable, because the multiplier reads op1 every cycle. On `mul_rdy_i`, compute `p = neg ? (~mul_res_i + 1) : mul_res_i` (64-bit), register `res = hi ? p[63:32] : p[31:0]`, then go to DONE.
- **DONE:** `res_vld_o=1`; `res_o` and `rd_idx_o` are held stable until `res_ack_i`. On ack go to IDLE. A new request is not accepted in the ack cycle.
- **Flush:**
  - IDLE: flush blocks acceptance in that cycle (flush wins over `vld_i`).
  - ISSUE: `mul_vld_o` is still driven that cycle, because the multiplier cannot be aborted; then go to DRAIN.
  - WAIT: go to DRAIN, or straight to IDLE if `mul_rdy_i` is high in the same cycle.
  - DONE: drop the result and go to IDLE; `res_vld_o` deasserts the next cycle.
- **DRAIN:** `rdy_o=0`, no output. Hold operands stable, wait for `mul_rdy_i`, discard the product, go to IDLE. `flush_i` is ignored in DRAIN.
- `mul_rdy_i` outside WAIT/DRAIN is ignored.

## Timing
- **Reset values:**
  - `rdy_o=1`, state IDLE
  - `res_vld_o=0`
  - `res_o=0`, `rd_idx_o=0`
  - `mul_vld_o=0`
  - `mul_op1_o=0`, `mul_op2_o=0`
- Asynchronous reset mid-operation returns the block to IDLE immediately. The multiplier shares the reset, so no drain is needed.
- All outputs are registered or decoded from the state register; no combinational path runs from `vld_i` to `rdy_o`.
- **Accept at edge T:**
  - ISSUE (`mul_vld_o=1`) during T+1.
  - The multiplier pulses `mul_rdy_i` at cycle W; with k = popcount(`mul_op2_o`) this is k+2 cycles after the `mul_vld_o` cycle.
  - `res_vld_o=1` from W+1.
  - Total accept-to-result latency is k+4 cycles.
- **Zero fast path:** `res_vld_o=1` at T+1.
- **Back-to-back throughput:** one request per (latency + 2) cycles at best (DONE ack → IDLE → accept).

## Test plan
- MUL `rs1=7`, `rs2=0xFFFFFFFD` -> `res_o=0xFFFFFFEB`, `rd_idx_o` equals the tag.
- MULH `rs1=rs2=0x80000000` -> `res_o=0x40000000`.
- MULHSU `rs1=0xFFFFFFFF`, `rs2=2` -> `res_o=0xFFFFFFFF`.
- MULHU `rs1=0xFFFFFFFF`, `rs2=0x00000003`, `SWAP_EN=1` -> `mul_op2_o=0x3`, `res_vld_o` 6 cycles after accept, `res_o=0x00000002`.
- MUL `rs1=0`, `rs2=5` -> `res_vld_o` at T+1, `res_o=0`, `mul_vld_o` never asserted. Hold `res_ack_i=0` for 10 cycles -> `res_o` stable and `rdy_o=0` throughout.
- MULHU `0x12345678 * 0xFFFF0000`, assert `flush_i` during WAIT:
  - `res_vld_o` stays 0.
  - `rdy_o` stays 0 until one cycle after `mul_rdy_i`.
  - A following MUL `3*4` then returns 12.

Source files
------------

// File: rtl/mul_ctrl.sv
// Sign-handling and sequencing front end for the iterative unsigned multiplier.
// Converts RV32M operands to magnitudes, issues them, and restores sign/word on return.
module mul_ctrl #(
    parameter bit SWAP_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vld_i,
    output logic        rdy_o,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [4:0]  rd_idx_i,
    input  logic        flush_i,
    output logic        res_vld_o,
    output logic [31:0] res_o,
    output logic [4:0]  rd_idx_o,
    input  logic        res_ack_i,
    output logic [31:0] mul_op1_o,
    output logic [31:0] mul_op2_o,
    output logic        mul_vld_o,
    input  logic [63:0] mul_res_i,
    input  logic        mul_rdy_i
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned PW    = 64;
    localparam int unsigned IDX_W = 5;
    localparam int unsigned PC_W  = 6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t             state_q;
    logic               rdy_q;
    logic               mul_vld_q;
    logic [XLEN-1:0]    op1_q;
    logic [XLEN-1:0]    op2_q;
    logic               neg_q;
    logic               hi_q;
    logic [XLEN-1:0]    res_q;
    logic               res_vld_q;
    logic [IDX_W-1:0]   rd_idx_q;

    logic               is_mulh_d;
    logic               is_mulhsu_d;
    logic               a_neg_d;
    logic               b_neg_d;
    logic [XLEN-1:0]    a_mag_d;
    logic [XLEN-1:0]    b_mag_d;
    logic [PC_W-1:0]    a_pc_d;
    logic [PC_W-1:0]    b_pc_d;
    logic               swap_d;
    logic               zero_d;
    logic               hi_d;
    logic [XLEN-1:0]    op1_d;
    logic [XLEN-1:0]    op2_d;
    logic [PW-1:0]      prod_d;
    logic [XLEN-1:0]    res_word_d;
    logic               accept_c;

    function automatic logic [PC_W-1:0] popcount(input logic [XLEN-1:0] x);
        logic [PC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(XLEN); i++) begin
            cnt = cnt + PC_W'(x[i]);
        end
        return cnt;
    endfunction

    // Request decode, magnitude conversion and latency-saving operand routing.
    always_comb begin
        is_mulh_d   = (funct3_i == 3'b001);
        is_mulhsu_d = (funct3_i == 3'b010);
        a_neg_d     = rs1_i[XLEN-1] & (is_mulh_d | is_mulhsu_d);
        b_neg_d     = rs2_i[XLEN-1] & is_mulh_d;
        a_mag_d     = a_neg_d ? XLEN'(~rs1_i + XLEN'(1)) : rs1_i;
        b_mag_d     = b_neg_d ? XLEN'(~rs2_i + XLEN'(1)) : rs2_i;
        a_pc_d      = popcount(a_mag_d);
        b_pc_d      = popcount(b_mag_d);
        swap_d      = SWAP_EN && (a_pc_d < b_pc_d);
        op1_d       = swap_d ? b_mag_d : a_mag_d;
        op2_d       = swap_d ? a_mag_d : b_mag_d;
        zero_d      = (rs1_i == '0) || (rs2_i == '0);
        hi_d        = (funct3_i != 3'b000);
        accept_c    = (state_q == S_IDLE) && vld_i && !flush_i;
    end

    // Sign restoration and word select on the returning product.
    always_comb begin
        prod_d     = neg_q ? PW'(~mul_res_i + PW'(1)) : mul_res_i;
        res_word_d = hi_q ? prod_d[PW-1:XLEN] : prod_d[XLEN-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rdy_q     <= 1'b1;
            mul_vld_q <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            neg_q     <= 1'b0;
            hi_q      <= 1'b0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
            rd_idx_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        rdy_q    <= 1'b0;
                        neg_q    <= a_neg_d ^ b_neg_d;
                        hi_q     <= hi_d;
                        rd_idx_q <= rd_idx_i;
                        if (zero_d) begin
                            res_q     <= '0;
                            res_vld_q <= 1'b1;
                            state_q   <= S_DONE;
                        end else begin
                            op1_q     <= op1_d;
                            op2_q     <= op2_d;
                            mul_vld_q <= 1'b1;
                            state_q   <= S_ISSUE;
                        end
                    end
                end
                // The start strobe already went out; a flush here must still drain.
                S_ISSUE: begin
                    mul_vld_q <= 1'b0;
                    state_q   <= flush_i ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (mul_rdy_i) begin
                        if (flush_i) begin
                            rdy_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            res_q     <= res_word_d;
                            res_vld_q <= 1'b1;
                            state_q   <= S_DONE;
                        end
                    end else if (flush_i) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    if (flush_i || res_ack_i) begin
                        res_vld_q <= 1'b0;
                        rdy_q     <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (mul_rdy_i) begin
                        rdy_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    mul_vld_q <= 1'b0;
                    res_vld_q <= 1'b0;
                    rdy_q     <= 1'b1;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign rdy_o     = rdy_q;
    assign res_vld_o = res_vld_q;
    assign res_o     = res_q;
    assign rd_idx_o  = rd_idx_q;
    assign mul_op1_o = op1_q;
    assign mul_op2_o = op2_q;
    assign mul_vld_o = mul_vld_q;

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed bench for mul_ctrl with a behavioural iterative multiplier
// whose result pulse arrives popcount(op2)+2 cycles after the start strobe.
module tb_mul_ctrl;

    logic        clk;
    logic        rst_n;
    logic        vld_i;
    logic        rdy_o;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [4:0]  rd_idx_i;
    logic        flush_i;
    logic        res_vld_o;
    logic [31:0] res_o;
    logic [4:0]  rd_idx_o;
    logic        res_ack_i;
    logic [31:0] mul_op1_o;
    logic [31:0] mul_op2_o;
    logic        mul_vld_o;
    logic [63:0] mul_res_i;
    logic        mul_rdy_i;

    int checks;
    int errors;
    int mul_vld_cnt;

    mul_ctrl #(.SWAP_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vld_i     (vld_i),
        .rdy_o     (rdy_o),
        .funct3_i  (funct3_i),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .rd_idx_i  (rd_idx_i),
        .flush_i   (flush_i),
        .res_vld_o (res_vld_o),
        .res_o     (res_o),
        .rd_idx_o  (rd_idx_o),
        .res_ack_i (res_ack_i),
        .mul_op1_o (mul_op1_o),
        .mul_op2_o (mul_op2_o),
        .mul_vld_o (mul_vld_o),
        .mul_res_i (mul_res_i),
        .mul_rdy_i (mul_rdy_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: strobe sampled at edge E -> product valid at edge E+k+2.
    initial begin
        mul_rdy_i = 1'b0;
        mul_res_i = '0;
        forever begin
            @(negedge clk);
            if (mul_vld_o === 1'b1) begin
                mul_vld_cnt++;
                repeat ($countones(mul_op2_o) + 2) @(negedge clk);
                mul_res_i = 64'(mul_op1_o) * 64'(mul_op2_o);
                mul_rdy_i = 1'b1;
                @(negedge clk);
                mul_rdy_i = 1'b0;
            end
        end
    end

    task automatic do_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, output int lat, output logic [31:0] op2_seen);
        int n;
        @(negedge clk);
        funct3_i = f3;
        rs1_i    = a;
        rs2_i    = b;
        rd_idx_i = tag;
        vld_i    = 1'b1;
        n = 0;
        while (rdy_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        vld_i    = 1'b0;
        op2_seen = mul_op2_o;
        lat = 1;
        while (res_vld_o !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_ack();
        res_ack_i = 1'b1;
        @(negedge clk);
        res_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rdy_o !== 1'b1 || res_vld_o !== 1'b0 || res_o !== 32'h0 || rd_idx_o !== 5'h0 ||
            mul_vld_o !== 1'b0 || mul_op1_o !== 32'h0 || mul_op2_o !== 32'h0) begin
            errors++;
            $display("FAIL reset: rdy=%b res_vld=%b res=%h rd=%h mvld=%b op1=%h op2=%h (want 1 0 0 0 0 0 0)",
                     rdy_o, res_vld_o, res_o, rd_idx_o, mul_vld_o, mul_op1_o, mul_op2_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul();
        int lat;
        logic [31:0] op2;
        do_req(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd9, lat, op2);
        checks++;
        if (res_o !== 32'hFFFF_FFEB || rd_idx_o !== 5'd9) begin
            errors++;
            $display("FAIL mul_neg: res=%h rd=%0d want FFFFFFEB rd=9", res_o, rd_idx_o);
        end
        checks++;
        if (lat !== 7 || op2 !== 32'd7) begin
            errors++;
            $display("FAIL mul_neg_lat: lat=%0d op2=%h want lat=7 op2=00000007", lat, op2);
        end
        do_ack();
    endtask

    task automatic test_mulh();
        int lat;
        logic [31:0] op2;
        do_req(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd3, lat, op2);
        checks++;
        if (res_o !== 32'h4000_0000 || lat !== 5) begin
            errors++;
            $display("FAIL mulh_min: res=%h lat=%0d want 40000000 lat=5", res_o, lat);
        end
        do_ack();
    endtask

    task automatic test_mulhsu();
        int lat;
        logic [31:0] op2;
        do_req(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd17, lat, op2);
        checks++;
        if (res_o !== 32'hFFFF_FFFF || rd_idx_o !== 5'd17 || op2 !== 32'd2) begin
            errors++;
            $display("FAIL mulhsu: res=%h rd=%0d op2=%h want FFFFFFFF rd=17 op2=00000002",
                     res_o, rd_idx_o, op2);
        end
        do_ack();
    endtask

    task automatic test_mulhu();
        int lat;
        logic [31:0] op2;
        do_req(3'b011, 32'hFFFF_FFFF, 32'h0000_0003, 5'd31, lat, op2);
        checks++;
        if (op2 !== 32'h3) begin
            errors++;
            $display("FAIL mulhu_swap: op2=%h want 00000003", op2);
        end
        checks++;
        if (lat !== 6) begin
            errors++;
            $display("FAIL mulhu_lat: lat=%0d want 6", lat);
        end
        checks++;
        if (res_o !== 32'h0000_0002) begin
            errors++;
            $display("FAIL mulhu_res: res=%h want 00000002", res_o);
        end
        do_ack();
        // funct3 1xx decodes as MULHU
        do_req(3'b110, 32'hFFFF_FFFF, 32'h0000_0003, 5'd4, lat, op2);
        checks++;
        if (res_o !== 32'h0000_0002 || lat !== 6) begin
            errors++;
            $display("FAIL f3_1xx: res=%h lat=%0d want 00000002 lat=6", res_o, lat);
        end
        do_ack();
    endtask

    task automatic test_zero();
        int lat;
        int start_cnt;
        logic [31:0] op2;
        start_cnt = mul_vld_cnt;
        do_req(3'b000, 32'd0, 32'd5, 5'd12, lat, op2);
        checks++;
        if (lat !== 1 || res_o !== 32'h0 || rd_idx_o !== 5'd12) begin
            errors++;
            $display("FAIL zero_fast: lat=%0d res=%h rd=%0d want lat=1 res=0 rd=12", lat, res_o, rd_idx_o);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (res_o !== 32'h0 || rdy_o !== 1'b0 || res_vld_o !== 1'b1) begin
                errors++;
                $display("FAIL zero_hold[%0d]: res=%h rdy=%b res_vld=%b want 0 0 1", i, res_o, rdy_o, res_vld_o);
            end
        end
        do_ack();
        checks++;
        if (mul_vld_cnt !== start_cnt || rdy_o !== 1'b1 || res_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_after: starts=%0d rdy=%b res_vld=%b want starts=%0d rdy=1 res_vld=0",
                     mul_vld_cnt - start_cnt, rdy_o, res_vld_o, 0);
        end
    endtask

    task automatic test_flush_idle_done();
        int lat;
        logic [31:0] op2;
        int start_cnt;
        start_cnt = mul_vld_cnt;
        @(negedge clk);
        funct3_i = 3'b000; rs1_i = 32'd6; rs2_i = 32'd7; rd_idx_i = 5'd1;
        vld_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        vld_i = 1'b0; flush_i = 1'b0;
        checks++;
        if (rdy_o !== 1'b1 || mul_vld_o !== 1'b0 || res_vld_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: rdy=%b mvld=%b res_vld=%b want 1 0 0", rdy_o, mul_vld_o, res_vld_o);
        end
        do_req(3'b000, 32'd5, 32'd0, 5'd2, lat, op2);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        checks++;
        if (res_vld_o !== 1'b0 || rdy_o !== 1'b1 || mul_vld_cnt !== start_cnt) begin
            errors++;
            $display("FAIL flush_done: res_vld=%b rdy=%b want 0 1", res_vld_o, rdy_o);
        end
    endtask

    task automatic test_flush_wait();
        int lat;
        int bad;
        logic [31:0] op2;
        @(negedge clk);
        funct3_i = 3'b011; rs1_i = 32'h1234_5678; rs2_i = 32'hFFFF_0000; rd_idx_i = 5'd7;
        vld_i = 1'b1;
        @(posedge clk);
        bad = 0;
        // popcount(0x12345678)=13 goes to op2: product pulse at edge +16, rdy_o back at negedge 17
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            if (i == 1) begin
                vld_i = 1'b0;
                checks++;
                if (mul_op2_o !== 32'h1234_5678 || mul_op1_o !== 32'hFFFF_0000) begin
                    errors++;
                    $display("FAIL flush_ops: op1=%h op2=%h want FFFF0000 12345678", mul_op1_o, mul_op2_o);
                end
            end
            flush_i = (i == 2);
            checks++;
            if (res_vld_o !== 1'b0 || rdy_o !== (i == 17)) begin
                errors++;
                $display("FAIL flush_wait[%0d]: res_vld=%b rdy=%b want 0 %b", i, res_vld_o, rdy_o, (i == 17));
            end
        end
        do_req(3'b000, 32'd3, 32'd4, 5'd21, lat, op2);
        checks++;
        if (res_o !== 32'd12 || rd_idx_o !== 5'd21 || lat !== 5) begin
            errors++;
            $display("FAIL after_flush: res=%0d rd=%0d lat=%0d want 12 rd=21 lat=5", res_o, rd_idx_o, lat);
        end
        do_ack();
    endtask

    initial begin
        checks = 0; errors = 0; mul_vld_cnt = 0;
        rst_n = 1'b0; vld_i = 1'b0; funct3_i = '0; rs1_i = '0; rs2_i = '0;
        rd_idx_i = '0; flush_i = 1'b0; res_ack_i = 1'b0;
        test_reset();
        test_mul();
        test_mulh();
        test_mulhsu();
        test_mulhu();
        test_zero();
        test_flush_idle_done();
        test_flush_wait();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
